// File: rtl/exception_unit_if.sv
// Exception unit bundle: EX-stage status in, pipeline control out.
// Master drives the EX-side inputs; slave is the exception unit.
interface exception_unit_if #(
  parameter int WIDTH = 32
);
  logic             overflow;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic             eret;
  logic             epc_we;
  logic [WIDTH-1:0] epc_wdata;
  logic             flush;
  logic             pc_redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] epc;
  logic [4:0]       cause;
  logic             exl;
  logic [7:0]       exc_count;

  modport master (
    output overflow, ex_valid, ex_pc,
    output eret, epc_we, epc_wdata,
    input  flush, pc_redirect, redirect_pc,
    input  epc, cause, exl, exc_count
  );

  modport slave (
    input  overflow, ex_valid, ex_pc,
    input  eret, epc_we, epc_wdata,
    output flush, pc_redirect, redirect_pc,
    output epc, cause, exl, exc_count
  );
endinterface

// File: rtl/exception_unit.sv
// Overflow exception sequencer: flush, vector, handler, ERET return.
// All outputs come straight from flops; inputs only steer next state.
module exception_unit #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] VECTOR = 32'h80000180
) (
  input logic             clk,
  input logic             reset,
  exception_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    HANDLER,
    RETURN
  } state_t;

  localparam logic [4:0] EXC_OV = 5'd12;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [4:0]       cause_q, cause_d;
  logic             exl_q, exl_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic [WIDTH-1:0] rpc_q, rpc_d;

  // Next state and next registered outputs for the exception sequence.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    redir_d = 1'b0;
    rpc_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.ex_valid && bus.overflow) begin
          state_d = FLUSH;
          epc_d   = bus.ex_pc;
          cause_d = EXC_OV;
          flush_d = 1'b1;
          if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        end
      end
      FLUSH: begin
        state_d = REDIRECT;
        redir_d = 1'b1;
        rpc_d   = VECTOR;
      end
      REDIRECT: begin
        state_d = HANDLER;
        exl_d   = 1'b1;
      end
      HANDLER: begin
        // A same-cycle EPC write lands before the return target is taken.
        if (bus.epc_we) epc_d = bus.epc_wdata;
        if (bus.eret) begin
          state_d = RETURN;
          redir_d = 1'b1;
          rpc_d   = epc_d;
        end
      end
      RETURN: begin
        state_d = IDLE;
        exl_d   = 1'b0;
        cause_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  assign bus.flush       = flush_q;
  assign bus.pc_redirect = redir_q;
  assign bus.redirect_pc = rpc_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.exl         = exl_q;
  assign bus.exc_count   = cnt_q;

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath/PC width.
REQ-002 SHALL have parameter VECTOR, default 32'h80000180, giving the exception handler entry address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port overflow, input, 1, arithmetic overflow flag from the ALU overflow detector for the instruction in EX.
REQ-006 SHALL have port ex_valid, input, 1, EX stage holds a real (non-bubble) instruction.
REQ-007 SHALL have port ex_pc, input, WIDTH, PC of the instruction in EX.
REQ-008 SHALL have port eret, input, 1, ERET instruction in EX.
REQ-009 SHALL have port epc_we, input, 1, software write strobe for EPC (MTC0).
REQ-010 SHALL have port epc_wdata, input, WIDTH, EPC write data.
REQ-011 SHALL have port flush, output, 1, kill IF/ID/EX contents.
REQ-012 SHALL have port pc_redirect, output, 1, force next PC to redirect_pc.
REQ-013 SHALL have port redirect_pc, output, WIDTH, target PC, valid when pc_redirect=1.
REQ-014 SHALL have port epc, output, WIDTH, exception PC register.
REQ-015 SHALL have port cause, output, 5, ExcCode register (12 = overflow, 0 = none).
REQ-016 SHALL have port exl, output, 1, exception level; high while in handler.
REQ-017 SHALL have port exc_count, output, 8, count of exceptions taken.

Function
REQ-018 SHALL implement FSM states IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
REQ-019 SHALL, in IDLE, take an exception when ex_valid=1 and overflow=1: latch epc<=ex_pc and cause<=12, then go to FLUSH.
REQ-020 SHALL ignore overflow when ex_valid=0, in every state.
REQ-021 SHALL drive flush=1 for exactly the one cycle spent in FLUSH, then go to REDIRECT.
REQ-022 SHALL drive pc_redirect=1 and redirect_pc=VECTOR for exactly the one cycle spent in REDIRECT, set exl<=1, and go to HANDLER.
REQ-023 SHALL give this latency: overflow sampled at edge N; flush high in cycle N+1; pc_redirect high in cycle N+2; exl high from edge N+2.
REQ-024 SHALL, in HANDLER, mask overflow: no state change and no epc, cause or exc_count update.
REQ-025 SHALL, in HANDLER, on eret=1 go to RETURN; eret in any other state SHALL be ignored.
REQ-026 SHALL, in RETURN, drive pc_redirect=1 with redirect_pc=epc for one cycle, clear exl and cause to 0 at the exit edge, and go to IDLE.
REQ-027 SHALL give eret priority over overflow in the same HANDLER cycle; the overflow is dropped.
REQ-028 SHALL write epc<=epc_wdata on epc_we=1 only in HANDLER; elsewhere epc_we SHALL be ignored.
REQ-029 SHALL give epc_we precedence over eret in the same HANDLER cycle: epc is written first, and RETURN redirects to the new value on the next cycle.
REQ-030 SHALL increment exc_count on each IDLE->FLUSH transition, saturating at 255.
REQ-031 SHALL drive flush=0, pc_redirect=0 and redirect_pc=0 in every state not named above for that output.
REQ-032 SHALL never assert flush and pc_redirect in the same cycle.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set: state IDLE, epc 0, cause 0, exl 0, exc_count 0, flush 0, pc_redirect 0, redirect_pc 0.
REQ-034 SHALL give reset priority over all other inputs, including mid-sequence (FLUSH, REDIRECT, RETURN); no partial redirect SHALL follow reset.
REQ-035 SHALL drive outputs from registered state only; there SHALL be no combinational path from inputs to flush or pc_redirect.

Verification
REQ-036 SHALL cover basic overflow: ex_valid=1, overflow=1, ex_pc=0x00400010 at edge N -> flush=1 at N+1; pc_redirect=1, redirect_pc=0x80000180 at N+2; epc=0x00400010, cause=12, exl=1, exc_count=1.
REQ-037 SHALL cover bubble: overflow=1 with ex_valid=0 -> no flush, no redirect, epc/cause/exc_count unchanged.
REQ-038 SHALL cover masking and return: in HANDLER, overflow=1 with ex_valid=1 (ex_pc=0x100) -> epc unchanged; then eret=1 -> next cycle pc_redirect=1, redirect_pc=0x00400010; exl=0, cause=0, state IDLE.
REQ-039 SHALL cover EPC write with ERET: in HANDLER, epc_we=1, epc_wdata=0x00400014, eret=1 in the same cycle -> RETURN redirect_pc=0x00400014.
REQ-040 SHALL cover reset mid-sequence: reset=1 in the FLUSH cycle -> next cycle all outputs 0, no pc_redirect pulse, state IDLE.
REQ-041 SHALL cover saturation: 256 exception/ERET round trips -> exc_count=255, no wrap.
